rtc_read_sequencer: RTL and testbench
=====================================

// Module: rtc_read_sequencer
// PURPOSE
//  Upstream feeder of the RTC register memory (memoria_DMULC). On each start tick it
//  reads 9 time/chrono registers from the external RTC through a bus-timing stage
//  (req/ack handshake). It writes them into the memory input bank via ADD1/DAT1/w1,
//  framed by whileT, then waits for the memory's actready before accepting a new frame.
// PARAMETERS
//  NREG          9    registers per frame (fixed map below; must be <= 9)
//  ACK_TIMEOUT   255  max cycles bus_req may wait for bus_ack before abort
//  READY_TIMEOUT 63   max cycles after whileT falls to wait for actready
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  reset      in   1  synchronous, active-high reset
//  start      in   1  one-cycle refresh request (e.g. from 1 Hz/irq tick)
//  bus_req    out  1  read request to bus-timing stage; held until bus_ack
//  bus_addr   out  8  external RTC register address; stable while bus_req=1
//  bus_ack    in   1  one-cycle pulse: read done, bus_rdata valid this cycle
//  bus_rdata  in   8  read data from external RTC
//  ADD1       out  4  memory write index
//  DAT1       out  8  memory write data
//  w1         out  1  memory write strobe, one cycle per register
//  whileT     out  1  frame window: high for the whole burst
//  actready   in   1  memory copy-complete flag
//  busy       out  1  high from frame accept until return to IDLE
//  err        out  1  sticky timeout flag; cleared on next accepted frame
// BEHAVIOUR
//  Reset: bus_req=0, bus_addr=0, ADD1=4'hF, DAT1=0, w1=0, whileT=0, busy=0, err=0,
//   pending=0, idx=0, FSM=IDLE. Reset mid-frame aborts immediately with the same values.
//  Map idx->(bus_addr,ADD1): 0:(21h,0) 1:(22h,1) 2:(23h,2) 3:(24h,3) 4:(25h,4)
//   5:(26h,5) 6:(41h,6) 7:(42h,7) 8:(43h,8) = sec,min,hr,day,month,year,chrono s/m/h.
//  Outside WRITE state, ADD1=4'hF and DAT1=0 (the memory writes ADD1 unconditionally in
//   its wait state; slot 15 is the scratch slot).
//  FSM:
//   IDLE   : start|pending -> REQ; err<=0, pending<=0, idx<=0, busy<=1, whileT<=1.
//   REQ    : bus_req=1, bus_addr=map(idx); ack-timer counts; bus_ack -> capture
//            bus_rdata, ->WRITE; timer==ACK_TIMEOUT -> err<=1, ->CLOSE (frame aborted).
//   WRITE  : w1=1 one cycle, ADD1=map(idx), DAT1=captured; idx==NREG-1 -> CLOSE,
//            else idx+1 -> REQ.
//   CLOSE  : whileT<=0 (exactly one cycle after last w1); ->WAITRDY.
//   WAITRDY: actready=1 -> IDLE (busy<=0); timer==READY_TIMEOUT -> err<=1, ->IDLE.
//  Latency per register: ack cycle + 1 write cycle; min frame = 2*NREG+2 cycles.
//  bus_ack outside REQ is ignored. start while busy sets pending (one-deep; extra
//   starts merge); start in IDLE same cycle as pending is one frame.
//  Timers are 8-bit, cleared on each entry to REQ/WAITRDY; no wrap (saturate at limit).
//  whileT never drops mid-burst except on ack timeout; aborted frame still runs
//   CLOSE/WAITRDY so the memory's state machine is returned to its idle state.
// STRUCTURE
//  Shared package/header (rtc_defs): RTC external addresses 21h-26h,41h-43h,
//   memory index constants 0-8, SCRATCH_IDX=4'hF, FSM state encodings.
//  Single module; the idx->address map is a small combinational case, no sub-module.
// TESTING
//  1 Normal frame: start, bench acks each req after 3 cycles with data 10h+idx ->
//    9 w1 pulses, ADD1=0..8, DAT1=10h..18h, whileT low 1 cycle after last w1, err=0.
//  2 Ack timeout: never ack idx 4 -> after 255 waits err=1, whileT drops, no w1 for
//    idx>=4; next start clears err and runs a full frame.
//  3 Start during busy: 3 starts mid-frame -> exactly one follow-up frame after actready.
//  4 Ready timeout: actready held 0 -> IDLE after 63 cycles, err=1, busy=0.
//  5 Reset mid-frame at idx 5 -> next cycle whileT=0, bus_req=0, ADD1=Fh, busy=0.
//  6 Idle safety: spurious bus_ack in IDLE -> no w1, ADD1 stays Fh, DAT1 stays 0.

Source files
------------

// File: rtl/rtc_read_sequencer_pkg.sv
// Shared definitions for the RTC read sequencer: external RTC register map,
// memory bank indices and FSM state encodings.
package rtc_read_sequencer_pkg;

  localparam logic [7:0] RTC_SEC  = 8'h21;
  localparam logic [7:0] RTC_MIN  = 8'h22;
  localparam logic [7:0] RTC_HR   = 8'h23;
  localparam logic [7:0] RTC_DAY  = 8'h24;
  localparam logic [7:0] RTC_MON  = 8'h25;
  localparam logic [7:0] RTC_YR   = 8'h26;
  localparam logic [7:0] RTC_CSEC = 8'h41;
  localparam logic [7:0] RTC_CMIN = 8'h42;
  localparam logic [7:0] RTC_CHR  = 8'h43;

  localparam logic [3:0] IDX_SEC     = 4'd0;
  localparam logic [3:0] IDX_MIN     = 4'd1;
  localparam logic [3:0] IDX_HR      = 4'd2;
  localparam logic [3:0] IDX_DAY     = 4'd3;
  localparam logic [3:0] IDX_MON     = 4'd4;
  localparam logic [3:0] IDX_YR      = 4'd5;
  localparam logic [3:0] IDX_CSEC    = 4'd6;
  localparam logic [3:0] IDX_CMIN    = 4'd7;
  localparam logic [3:0] IDX_CHR     = 4'd8;
  localparam logic [3:0] SCRATCH_IDX = 4'hF;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_CLOSE   = 3'd3;
  localparam logic [2:0] ST_WAITRDY = 3'd4;

  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return RTC_SEC;
      4'd1:    return RTC_MIN;
      4'd2:    return RTC_HR;
      4'd3:    return RTC_DAY;
      4'd4:    return RTC_MON;
      4'd5:    return RTC_YR;
      4'd6:    return RTC_CSEC;
      4'd7:    return RTC_CMIN;
      4'd8:    return RTC_CHR;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [3:0] mem_idx(input logic [3:0] idx);
    case (idx)
      4'd0:    return IDX_SEC;
      4'd1:    return IDX_MIN;
      4'd2:    return IDX_HR;
      4'd3:    return IDX_DAY;
      4'd4:    return IDX_MON;
      4'd5:    return IDX_YR;
      4'd6:    return IDX_CSEC;
      4'd7:    return IDX_CMIN;
      4'd8:    return IDX_CHR;
      default: return SCRATCH_IDX;
    endcase
  endfunction

endpackage

// File: rtl/rtc_read_sequencer.sv
// Reads the RTC time/chrono registers over a req/ack bus on each start tick and
// bursts them into the register memory's input bank, framed by whileT.
module rtc_read_sequencer
  import rtc_read_sequencer_pkg::*;
#(
  parameter int NREG          = 9,
  parameter int ACK_TIMEOUT   = 255,
  parameter int READY_TIMEOUT = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       bus_req,
  output logic [7:0] bus_addr,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic [3:0] ADD1,
  output logic [7:0] DAT1,
  output logic       w1,
  output logic       whileT,
  input  logic       actready,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] LAST_IDX = 4'(NREG - 1);
  localparam logic [7:0] ACK_LIM  = 8'(ACK_TIMEOUT);
  localparam logic [7:0] RDY_LIM  = 8'(READY_TIMEOUT);

  logic [2:0] state;
  logic [3:0] idx;
  logic [7:0] timer;
  logic [7:0] data;
  logic       pending;

  // Outside WRITE the memory still latches ADD1, so park it on the scratch slot.
  always_comb begin
    bus_req  = 1'b0;
    bus_addr = 8'h00;
    w1       = 1'b0;
    ADD1     = SCRATCH_IDX;
    DAT1     = 8'h00;
    if (state == ST_REQ) begin
      bus_req  = 1'b1;
      bus_addr = rtc_addr(idx);
    end
    if (state == ST_WRITE) begin
      w1   = 1'b1;
      ADD1 = mem_idx(idx);
      DAT1 = data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= 4'd0;
      timer   <= 8'd0;
      data    <= 8'h00;
      pending <= 1'b0;
      whileT  <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (start && busy) pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start || pending) begin
            state   <= ST_REQ;
            err     <= 1'b0;
            pending <= 1'b0;
            idx     <= 4'd0;
            timer   <= 8'd0;
            busy    <= 1'b1;
            whileT  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            data  <= bus_rdata;
            state <= ST_WRITE;
          end else if (timer == ACK_LIM) begin
            // Aborted frame still closes and waits so the memory FSM returns to idle.
            err    <= 1'b1;
            whileT <= 1'b0;
            state  <= ST_CLOSE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_WRITE: begin
          if (idx == LAST_IDX) begin
            whileT <= 1'b0;
            state  <= ST_CLOSE;
          end else begin
            idx   <= idx + 4'd1;
            timer <= 8'd0;
            state <= ST_REQ;
          end
        end
        ST_CLOSE: begin
          timer <= 8'd0;
          state <= ST_WAITRDY;
        end
        ST_WAITRDY: begin
          if (actready) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (timer == RDY_LIM) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed bench for rtc_read_sequencer: bus responder, write monitor and
// hand-computed frame lengths / write contents.
module tb_rtc_read_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       bus_req;
  logic [7:0] bus_addr;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic [3:0] ADD1;
  logic [7:0] DAT1;
  logic       w1;
  logic       whileT;
  logic       actready;
  logic       busy;
  logic       err;

  rtc_read_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .ADD1(ADD1), .DAT1(DAT1), .w1(w1), .whileT(whileT),
    .actready(actready), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] addr_tab [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  logic [3:0] wq_add [$];
  logic [7:0] wq_dat [$];

  int  drop_idx = -1;
  bit  resp_en  = 1'b1;
  bit  spur     = 1'b0;
  bit  mon_en   = 1'b0;
  int  frames   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int find_idx(input logic [7:0] a);
    for (int i = 0; i < 9; i++)
      if (addr_tab[i] == a) return i;
    return -1;
  endfunction

  // Bus-timing stand-in: ack on the 3rd cycle of each request with data 10h+idx.
  initial begin
    int wcnt;
    int k;
    wcnt = 0;
    bus_ack = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_ack = spur;
      if (spur) bus_rdata = 8'hAA;
      if (resp_en && bus_req) begin
        wcnt++;
        k = find_idx(bus_addr);
        if (wcnt >= 3 && k >= 0 && k != drop_idx) begin
          bus_ack   = 1'b1;
          bus_rdata = 8'(8'h10 + k);
          wcnt      = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    bit prev_last;
    bit prev_busy;
    prev_last = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (w1) begin
          wq_add.push_back(ADD1);
          wq_dat.push_back(DAT1);
          chk("whileT_in_burst", 32'(whileT), 32'd1);
        end else begin
          chk("add1_scratch", 32'(ADD1), 32'hF);
          chk("dat1_zero", 32'(DAT1), 32'h0);
        end
        if (prev_last) chk("whileT_fall", 32'(whileT), 32'd0);
        prev_last = w1 && (ADD1 == 4'd8);
        if (busy && !prev_busy) frames++;
        prev_busy = busy;
      end
    end
  end

  task automatic clr_log();
    wq_add.delete();
    wq_dat.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string tag, output int n);
    n = 0;
    while (busy && n < limit) begin
      n++;
      @(negedge clk);
    end
    if (n >= limit) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic chk_full_frame(input string tag);
    chk({tag, "_nw"}, 32'(wq_add.size()), 32'd9);
    if (wq_add.size() == 9)
      for (int i = 0; i < 9; i++) begin
        chk({tag, "_add1"}, 32'(wq_add[i]), 32'(i));
        chk({tag, "_dat1"}, 32'(wq_dat[i]), 32'(8'h10 + i));
      end
  endtask

  initial begin
    int n;
    bit found;
    reset = 1'b1;
    start = 1'b0;
    actready = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", 32'(bus_addr), 32'h0);
    chk("rst_add1", 32'(ADD1), 32'hF);
    chk("rst_dat1", 32'(DAT1), 32'h0);
    chk("rst_w1", 32'(w1), 32'd0);
    chk("rst_whileT", 32'(whileT), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Normal frame: 9 x (3 req + 1 write) + CLOSE + WAITRDY = 38 busy cycles.
    clr_log();
    pulse_start();
    chk("t1_whileT_up", 32'(whileT), 32'd1);
    wait_idle(200, "t1", n);
    chk("t1_cycles", 32'(n), 32'd38);
    chk_full_frame("t1");
    chk("t1_err", 32'(err), 32'd0);

    // Ack timeout at idx 4: 16 + 256 + 2 = 274 busy cycles.
    clr_log();
    drop_idx = 4;
    pulse_start();
    wait_idle(600, "t2", n);
    chk("t2_cycles", 32'(n), 32'd274);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_nw", 32'(wq_add.size()), 32'd4);
    drop_idx = -1;
    clr_log();
    pulse_start();
    chk("t2_err_clr", 32'(err), 32'd0);
    wait_idle(200, "t2b", n);
    chk_full_frame("t2b");
    chk("t2b_err", 32'(err), 32'd0);

    // Three starts while busy merge into one follow-up frame.
    clr_log();
    frames = 0;
    pulse_start();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      repeat (3) @(negedge clk);
    end
    wait_idle(200, "t3a", n);
    repeat (3) @(negedge clk);
    wait_idle(200, "t3b", n);
    repeat (30) @(negedge clk);
    chk("t3_frames", 32'(frames), 32'd2);
    chk("t3_nw", 32'(wq_add.size()), 32'd18);
    chk("t3_busy", 32'(busy), 32'd0);

    // Ready timeout: 36 + CLOSE + 64 WAITRDY = 101 busy cycles.
    actready = 1'b0;
    pulse_start();
    wait_idle(300, "t4", n);
    chk("t4_cycles", 32'(n), 32'd101);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    actready = 1'b1;
    @(negedge clk);

    // Reset while requesting idx 5.
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus_req && bus_addr == 8'h26) found = 1'b1;
      else @(negedge clk);
    end
    chk("t5_reached_idx5", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_whileT", 32'(whileT), 32'd0);
    chk("t5_bus_req", 32'(bus_req), 32'd0);
    chk("t5_add1", 32'(ADD1), 32'hF);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_w1", 32'(w1), 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_no_restart", 32'(busy), 32'd0);

    // Spurious ack in IDLE must not write.
    clr_log();
    resp_en = 1'b0;
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_nw", 32'(wq_add.size()), 32'd0);
    chk("t6_add1", 32'(ADD1), 32'hF);
    chk("t6_dat1", 32'(DAT1), 32'h0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
